// File: rtl/fft_frame_sched_if.sv
// Control bundle between the FFT frame scheduler and its surroundings
// (UART byte strobe, buffer-RAM controls, FFT core handshake).
interface fft_frame_sched_if #(
    parameter int SIZE = 4
);
    logic            rx_valid;
    logic            wr_en;
    logic            wr_bank;
    logic [SIZE-1:0] wr_addr;
    logic            wr_im;
    logic            drop_o;
    logic [7:0]      overrun_cnt;
    logic [1:0]      bank_full;
    logic            core_ready;
    logic            core_done;
    logic            rd_en;
    logic            rd_bank;
    logic [SIZE-1:0] rd_addr;
    logic [SIZE-1:0] rd_idx;
    logic            sop;
    logic            eop;

    modport master (
        input  rx_valid, core_ready, core_done,
        output wr_en, wr_bank, wr_addr, wr_im, drop_o, overrun_cnt, bank_full,
        output rd_en, rd_bank, rd_addr, rd_idx, sop, eop
    );

    modport slave (
        output rx_valid, core_ready, core_done,
        input  wr_en, wr_bank, wr_addr, wr_im, drop_o, overrun_cnt, bank_full,
        input  rd_en, rd_bank, rd_addr, rd_idx, sop, eop
    );
endinterface

// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler: fills two external banks from UART bytes and
// streams each full bank to the FFT core in bit-reversed order.
module fft_frame_sched #(
    parameter int N    = 16,
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    fft_frame_sched_if.master bus
);
    typedef enum logic {W_FILL, W_BLOCK} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT} rstate_t;
    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bstate_t;

    localparam logic [SIZE:0]   WR_LAST = (SIZE+1)'(2*N-1);
    localparam logic [SIZE-1:0] RD_LAST = SIZE'(N-1);

    wstate_t         wst_q, wst_d;
    logic            wr_bank_q, wr_bank_d;
    logic [SIZE:0]   wr_cnt_q, wr_cnt_d;
    logic [7:0]      ovr_q, ovr_d;
    rstate_t         rdst_q, rdst_d;
    logic            rd_bank_q, rd_bank_d;
    logic [SIZE-1:0] rd_cnt_q, rd_cnt_d;
    bstate_t [1:0]   bank_q, bank_d;

    logic blocked;
    logic other_bank;
    logic rd_release;
    logic other_free;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [SIZE-1:0] bit_rev(input logic [SIZE-1:0] v);
        logic [SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i] = v[SIZE-1-i];
        return r;
    endfunction

    // The writer may switch banks on the same edge that releases the other
    // bank, so the byte right after the eop cycle lands in the freed bank.
    always_comb begin
        blocked    = (wst_q == W_BLOCK);
        other_bank = ~wr_bank_q;
        rd_release = (rdst_q == R_READ) && (rd_cnt_q == RD_LAST);
        other_free = (bank_q[other_bank] == B_EMPTY) ||
                     (rd_release && (rd_bank_q == other_bank));
    end

    always_comb begin
        wst_d     = wst_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        ovr_d     = ovr_q;
        rdst_d    = rdst_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];

        case (rdst_q)
            R_IDLE: begin
                if ((bank_q[rd_bank_q] == B_FULL) && bus.core_ready) begin
                    bank_d[rd_bank_q] = B_READING;
                    rd_cnt_d          = '0;
                    rdst_d            = R_READ;
                end
            end
            R_READ: begin
                rd_cnt_d = rd_cnt_q + SIZE'(1);
                if (rd_release) begin
                    bank_d[rd_bank_q] = B_EMPTY;
                    rd_bank_d         = ~rd_bank_q;
                    rdst_d            = R_WAIT;
                end
            end
            R_WAIT: begin
                if (bus.core_done) rdst_d = R_IDLE;
            end
            default: rdst_d = R_IDLE;
        endcase

        // Reader only ever touches a FULL/READING bank, the writer only the
        // bank it is filling, so the two updates never collide.
        case (wst_q)
            W_FILL: begin
                if (bus.rx_valid) begin
                    if (wr_cnt_q == WR_LAST) begin
                        bank_d[wr_bank_q] = B_FULL;
                        wr_cnt_d          = '0;
                        if (other_free) wr_bank_d = other_bank;
                        else            wst_d     = W_BLOCK;
                    end else begin
                        wr_cnt_d = wr_cnt_q + (SIZE+1)'(1);
                    end
                end
            end
            W_BLOCK: begin
                if (bus.rx_valid) ovr_d = sat_inc8(ovr_q);
                if (other_free) begin
                    wst_d     = W_FILL;
                    wr_bank_d = other_bank;
                end
            end
            default: wst_d = W_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q     <= W_FILL;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            ovr_q     <= '0;
            rdst_q    <= R_IDLE;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            bank_q[0] <= B_EMPTY;
            bank_q[1] <= B_EMPTY;
        end else begin
            wst_q     <= wst_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            ovr_q     <= ovr_d;
            rdst_q    <= rdst_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    // Write side is the only path with a combinational input (rx_valid).
    assign bus.wr_en       = bus.rx_valid & ~blocked;
    assign bus.drop_o      = bus.rx_valid & blocked;
    assign bus.wr_bank     = wr_bank_q;
    assign bus.wr_addr     = wr_cnt_q[SIZE-1:0];
    assign bus.wr_im       = wr_cnt_q[SIZE];
    assign bus.overrun_cnt = ovr_q;
    assign bus.bank_full   = {bank_q[1] == B_FULL, bank_q[0] == B_FULL};

    assign bus.rd_en   = (rdst_q == R_READ);
    assign bus.rd_bank = rd_bank_q;
    assign bus.rd_addr = bit_rev(rd_cnt_q);
    assign bus.rd_idx  = rd_cnt_q;
    assign bus.sop     = (rdst_q == R_READ) && (rd_cnt_q == '0);
    assign bus.eop     = (rdst_q == R_READ) && (rd_cnt_q == RD_LAST);
endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: table-driven single frame, directed corner
// sequences, and random traffic against a bank-level reference model.
module tb_fft_frame_sched;
    localparam int N    = 16;
    localparam int SIZE = 4;
    localparam int VW   = 18 + 3*SIZE;
    localparam logic [1:0] ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_READING = 2'd2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    fft_frame_sched_if #(.SIZE(SIZE)) bus ();
    fft_frame_sched #(.N(N), .SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: per-bank status, fill position, reader phase.
    typedef struct packed {
        int              wbank, wcnt, ovr, rmode, rbank, ridx;
        logic            blocked;
        logic [1:0][1:0] st;
    } mstate_t;
    mstate_t m;

    function automatic int rev(int v);
        int r = 0;
        for (int i = 0; i < SIZE; i++) r = r*2 + (v / (2**i)) % 2;
        return r;
    endfunction

    function automatic mstate_t m_next(mstate_t s, logic rx, logic ready, logic done);
        mstate_t n = s;
        int other;
        if (s.rmode == 0) begin
            if (s.st[s.rbank] == ST_FULL && ready) begin
                n.st[s.rbank] = ST_READING; n.rmode = 1; n.ridx = 0;
            end
        end else if (s.rmode == 1) begin
            if (s.ridx == N-1) begin
                n.st[s.rbank] = ST_EMPTY; n.rbank = 1 - s.rbank; n.rmode = 2; n.ridx = 0;
            end else n.ridx = s.ridx + 1;
        end else if (done) n.rmode = 0;
        other = 1 - s.wbank;
        if (!s.blocked) begin
            if (rx) begin
                if (s.wcnt == 2*N-1) begin
                    n.st[s.wbank] = ST_FULL; n.wcnt = 0;
                    if (n.st[other] == ST_EMPTY) n.wbank = other; else n.blocked = 1'b1;
                end else n.wcnt = s.wcnt + 1;
            end
        end else begin
            if (rx) n.ovr = (s.ovr < 255) ? s.ovr + 1 : 255;
            if (n.st[other] == ST_EMPTY) begin n.blocked = 1'b0; n.wbank = other; end
        end
        return n;
    endfunction

    function automatic logic [VW-1:0] exp_vec(mstate_t s, logic rx);
        logic rde;
        rde = (s.rmode == 1);
        return {rx & ~s.blocked, rx & s.blocked, 1'(s.wbank), SIZE'(s.wcnt % N), 1'(s.wcnt / N),
                8'(s.ovr), s.st[1] == ST_FULL, s.st[0] == ST_FULL, rde, 1'(s.rbank),
                SIZE'(rev(s.ridx)), SIZE'(s.ridx), rde && s.ridx == 0, rde && s.ridx == N-1};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.wr_en, bus.drop_o, bus.wr_bank, bus.wr_addr, bus.wr_im, bus.overrun_cnt,
                bus.bank_full, bus.rd_en, bus.rd_bank, bus.rd_addr, bus.rd_idx, bus.sop, bus.eop};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= m_next(m, bus.rx_valid, bus.core_ready, bus.core_done);
    end

    always @(negedge clk) begin
        if (!rst) check("model", 64'(act_vec()), 64'(exp_vec(m, bus.rx_valid)));
    end

    typedef struct {
        logic            rx;
        logic            e_wen;
        logic            e_wbank;
        logic [SIZE-1:0] e_waddr;
        logic            e_wim;
        logic [1:0]      e_full;
        logic            e_rden;
        logic [SIZE-1:0] e_raddr;
        logic            e_sop;
        logic            e_eop;
    } vec_t;
    vec_t tab[50];
    int   rev_list[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        bus.rx_valid = 1'b0; bus.core_ready = 1'b0; bus.core_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        bit got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.rd_en) got = 1'b1; else tick();
        end
        check(name, 64'(got), 64'd1);
    endtask

    initial begin
        int cnt, bad;
        bit got;
        rst = 1'b1;
        bus.rx_valid = 1'b0; bus.core_ready = 1'b0; bus.core_done = 1'b0;

        for (int i = 0; i < 32; i++)
            tab[i] = '{1'b1, 1'b1, 1'b0, SIZE'(i % N), 1'(i / N), 2'b00, 1'b0, SIZE'(0), 1'b0, 1'b0};
        tab[32] = '{1'b0, 1'b0, 1'b1, SIZE'(0), 1'b0, 2'b01, 1'b0, SIZE'(0), 1'b0, 1'b0};
        for (int k = 0; k < 16; k++)
            tab[33+k] = '{1'b0, 1'b0, 1'b1, SIZE'(0), 1'b0, 2'b00, 1'b1, SIZE'(rev_list[k]), k == 0, k == 15};
        tab[49] = '{1'b0, 1'b0, 1'b1, SIZE'(0), 1'b0, 2'b00, 1'b0, SIZE'(0), 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(act_vec()), 64'd0);
        tick();

        // Single frame, table driven
        apply_reset();
        bus.core_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.rx_valid = tab[i].rx;
            @(negedge clk);
            check($sformatf("frame_vec[%0d]", i),
                  64'({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_im, bus.bank_full,
                       bus.rd_en, bus.rd_addr, bus.sop, bus.eop}),
                  64'({tab[i].e_wen, tab[i].e_wbank, tab[i].e_waddr, tab[i].e_wim, tab[i].e_full,
                       tab[i].e_rden, tab[i].e_raddr, tab[i].e_sop, tab[i].e_eop}));
            tick();
        end

        // Ping-pong
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            bus.rx_valid = 1'b1;
            @(negedge clk); cnt += int'(bus.drop_o);
            tick();
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("pp_full", 64'(bus.bank_full), 64'h3);
        check("pp_no_drops", 64'(cnt), 64'd0);
        tick();
        bus.core_ready = 1'b1;
        wait_rd("pp_rd1_start");
        check("pp_bank0_first", 64'({bus.rd_bank, bus.sop}), 64'h1);
        tick();
        repeat (15) tick();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); cnt += int'(bus.rd_en);
            tick();
        end
        check("pp_hold_until_done", 64'(cnt), 64'd0);
        check("pp_full_waiting", 64'(bus.bank_full), 64'h2);
        bus.core_done = 1'b1; tick(); bus.core_done = 1'b0;
        wait_rd("pp_rd2_start");
        check("pp_bank1_second", 64'({bus.rd_bank, bus.sop}), 64'h3);
        tick();

        // Overrun
        apply_reset();
        cnt = 0; bad = 0;
        for (int i = 0; i < 96; i++) begin
            bus.rx_valid = 1'b1;
            @(negedge clk);
            cnt += int'(bus.drop_o);
            if (i >= 64 && bus.wr_en) bad++;
            tick();
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("ovr_drop_pulses", 64'(cnt), 64'd32);
        check("ovr_wen_during_drop", 64'(bad), 64'd0);
        check("ovr_count", 64'(bus.overrun_cnt), 64'd32);
        tick();

        // Release collision: byte in the eop cycle dropped, next one written
        bus.core_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (bus.eop) got = 1'b1; else tick();
        end
        check("col_eop_seen", 64'(got), 64'd1);
        bus.rx_valid = 1'b1;
        @(negedge clk);
        check("col_drop", 64'({bus.drop_o, bus.wr_en}), 64'h2);
        tick();
        @(negedge clk);
        check("col_write", 64'({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_im}),
              64'({1'b1, 1'b0, SIZE'(0), 1'b0}));
        tick();
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("col_ovr", 64'(bus.overrun_cnt), 64'd33);
        tick();

        // Counter saturation
        apply_reset();
        bus.rx_valid = 1'b1;
        repeat (364) tick();
        @(negedge clk);
        check("sat_drop_still", 64'(bus.drop_o), 64'd1);
        check("sat_count", 64'(bus.overrun_cnt), 64'd255);
        tick();
        bus.rx_valid = 1'b0;

        // Reset in the middle of a read
        apply_reset();
        bus.core_ready = 1'b1;
        bus.rx_valid = 1'b1;
        repeat (32) tick();
        bus.rx_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (bus.rd_en && bus.rd_idx == SIZE'(5)) got = 1'b1; else tick();
        end
        check("rr_reached_idx5", 64'(got), 64'd1);
        #2 rst = 1'b1;
        #1 check("rr_async_zero", 64'(act_vec()), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rx_valid = 1'b1;
            @(negedge clk);
            check("rr_refill", 64'({bus.wr_en, bus.wr_bank, bus.wr_im, bus.wr_addr}),
                  64'({1'b1, 1'b0, 1'(i / N), SIZE'(i % N)}));
            tick();
        end
        bus.rx_valid = 1'b0;
        wait_rd("rr_rd_start");
        check("rr_rd_first", 64'({bus.rd_bank, bus.rd_idx, bus.sop}), 64'h1);
        cnt = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            @(negedge clk); cnt += int'(bus.rd_en);
        end
        check("rr_rd_len", 64'(cnt), 64'd16);
        tick();

        // Random traffic, compared against the model every cycle
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.rx_valid   = ($urandom_range(0, 99) < 60);
            bus.core_ready = ($urandom_range(0, 99) < 70);
            bus.core_done  = ($urandom_range(0, 99) < 15);
            tick();
        end
        bus.rx_valid = 1'b0; bus.core_ready = 1'b0; bus.core_done = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Ping-pong frame scheduler for the FFT front end. Counts incoming UART sample bytes into one of two external frame banks, marks a bank full after 2·N bytes, and streams full banks to the FFT core in bit-reversed read order with sop/eop framing. A frame is read only when the core reports ready, and the next frame waits for the core's done pulse. The block holds no sample data: it drives bank/address/enable controls for the buffer RAM and the core handshake only.

## Interface
- N, 16, points per frame; power of two, ≥4
- SIZE, 4, log2(N)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: a sample byte is on the datapath this cycle
- wr_en  out  1  RAM write strobe; combinational: rx_valid & write side not blocked
- wr_bank  out  1  bank being filled (registered)
- wr_addr  out  SIZE  sample index in bank = wr_cnt[SIZE-1:0] (registered)
- wr_im  out  1  0 = Re half, 1 = Im half = wr_cnt[SIZE] (registered)
- drop_o  out  1  combinational: rx_valid & write side blocked
- overrun_cnt  out  8  dropped-byte count, saturates at 255
- bank_full  out  2  per-bank FULL flag
- core_ready  in  1  FFT core can accept a frame (sampled in R_IDLE only)
- core_done  in  1  one-cycle pulse: core finished the current frame
- rd_en  out  1  registered: read address valid
- rd_bank  out  1  bank being read
- rd_addr  out  SIZE  bit-reversed read index, rd_addr[i] = rd_cnt[SIZE-1-i]
- rd_idx  out  SIZE  natural-order index (rd_cnt)
- sop  out  1  high with rd_en when rd_cnt = 0
- eop  out  1  high with rd_en when rd_cnt = N-1

## Operation
- Bank state per bank: EMPTY, FULL, READING. Bank FILLING is implied by wr_bank plus the write side in W_FILL.
- Write FSM: W_FILL and W_BLOCK.
  - W_FILL: each rx_valid writes at wr_cnt, then wr_cnt++ (width SIZE+1, counts 0..2N-1).
  - On rx_valid with wr_cnt = 2N-1: wr_bank becomes FULL, wr_cnt←0. Next state is W_FILL on the other bank if that bank is EMPTY, else W_BLOCK.
  - W_BLOCK: every rx_valid is dropped (drop_o=1, overrun_cnt++). The FSM leaves W_BLOCK on the edge after the other bank becomes EMPTY, switching wr_bank to that bank.
- Read FSM: R_IDLE, R_READ, R_WAIT.
  - R_IDLE: if bank_full[rd_bank] & core_ready, mark that bank READING and go to R_READ, rd_cnt←0. rd_bank strictly alternates, so banks are consumed in fill order.
  - R_READ: rd_en=1 for exactly N consecutive cycles; rd_cnt++ each cycle.
  - Edge ending the eop cycle: bank→EMPTY, rd_bank toggles, go to R_WAIT.
  - R_WAIT: rd_en=0. On core_done go to R_IDLE. A core_done pulse seen in R_IDLE or R_READ is ignored.
- Partial frames are never read. A bank is FULL only after exactly 2N bytes.

## Timing
- Reset (async, immediate) values:
  - all outputs 0, bank_full=00, wr_bank=rd_bank=0, counters 0
  - states W_FILL / R_IDLE
  - any partially filled or unread frame is discarded
- Write path: zero latency. wr_en, wr_addr and wr_im are valid in the same cycle as rx_valid. wr_addr/wr_im advance on that cycle's edge.
- bank_full sets on the edge that takes the last byte. First rd_en (with sop) appears on the next edge, provided core_ready was 1 in that intervening cycle.
- eop is followed by at least one cycle of rd_en=0. The minimum gap between eop and the next sop is 2 cycles (R_WAIT with core_done in its first cycle, then R_IDLE).
- Bank release vs rx_valid in the same cycle: release is not yet visible, so that byte is dropped. A byte on the following cycle is written to address 0 of the freed bank.
- Last byte of a bank in the same cycle that R_IDLE tests that bank: it is not seen as full until the next cycle.
- No combinational path from core_ready or core_done to any output.

## Test plan
- **Single frame, N=16:** 32 rx_valid strobes with core_ready=1.
  - Writes go to bank 0: wr_im=0 with addr 0..15, then wr_im=1 with addr 0..15.
  - bank_full=01 after byte 32, then rd_en for 16 cycles one edge later.
  - rd_addr sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; sop on the first cycle, eop on the last.
- **Ping-pong:** 64 back-to-back bytes, core_ready=0 until byte 64.
  - Both flags set (bank_full=11), no drops.
  - After raising core_ready: bank 0 is read first; bank 1 is read only after a core_done pulse.
- **Overrun:** 96 bytes with core_ready=0.
  - Bytes 65–96 are dropped; drop_o pulses 32 times; overrun_cnt=32.
  - wr_en stays 0 during the drops.
- **Release collision:** write side in W_BLOCK, rx_valid in the eop cycle.
  - That byte is dropped.
  - A byte on the next cycle is written to the freed bank with wr_addr=0, wr_im=0.
- **Counter saturation:** 300 bytes dropped → overrun_cnt holds at 255.
- **Reset mid-read:** assert rst at rd_cnt=5.
  - All outputs 0 immediately.
  - After release, 32 new bytes land in bank 0 from address 0, and a full read follows normally.
